// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch with a valid/ready decode port and redirect flush
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [5:0]         if_opcode,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic drop_q, drop_d, req_q, req_d, if_valid_q, if_valid_d;
  logic redir, rsp_take;
  assign redir = redirect_valid && state_q != IDLE;
  assign rsp_take = state_q == WAIT && imem_rsp_valid && !redir;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      req_q      <= req_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end
  always_comb begin
    state_d = redir              ? REQ
            : state_q == IDLE    ? REQ
            : state_q == REQ     ? ((req_q && imem_req_ready) ? WAIT : REQ)
            : state_q == WAIT    ? (imem_rsp_valid ? HOLD : WAIT)
            : (if_ready ? REQ : HOLD);
  end
  // drop marks one response still owed by memory for a flushed request; it only lives in REQ
  always_comb begin
    pc_d       = redir ? redirect_pc : rsp_take ? pc_q + ADDR_W'(PC_STEP) : pc_q;
    drop_d     = drop_q ? !imem_rsp_valid
               : redir && (state_q == WAIT ? !imem_rsp_valid : state_q == REQ && req_q && imem_req_ready);
    if_valid_d = !redir && (rsp_take || (if_valid_q && !if_ready));
    if_instr_d = rsp_take ? imem_rsp_data : if_instr_q;
    if_pc_d    = rsp_take ? pc_q : if_pc_q;
    req_d      = state_d == REQ && !drop_d;
  end
  assign imem_req_valid = req_q;
  assign imem_addr      = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_opcode      = if_instr_q[INSTR_W-1 -: 6];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with queued expected fetch addresses and delivered instructions
module tb_instr_fetch_unit;
  logic        clk = 0;
  logic        rst = 1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        if_valid;
  logic        if_ready = 1;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int cnt = 0;
  logic [31:0] maddr = 0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_out[$];
  logic [31:0] ea;
  logic [63:0] eo;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_opcode(if_opcode), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 0 ? 32'h8C41_0004 : {8'hA0, a[23:0]};
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(imem_req_valid && imem_addr == a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_req: no request to %h within bound", a);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!if_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_valid: if_valid never rose");
    end
  endtask

  // memory: returns the word mem_lat cycles after acceptance
  always begin
    @(negedge clk);
    #1;
    imem_rsp_valid = 0;
    if (rst) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1;
          imem_rsp_data  = mem_word(maddr);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        maddr = imem_addr;
        cnt   = mem_lat;
      end
    end
  end

  // monitor: accepted requests and consumed instructions against the queues
  always begin
    @(negedge clk);
    #2;
    if (!rst && imem_req_valid && imem_req_ready) begin
      if (exp_addr.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_addr: unexpected request to %h", imem_addr);
      end else begin
        ea = exp_addr.pop_front();
        chk("req_addr", {32'h0, imem_addr}, {32'h0, ea});
      end
    end
    if (!rst && if_valid && if_ready && !redirect_valid) begin
      if (exp_out.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_out: unexpected instr %h at pc %h", if_instr, if_pc);
      end else begin
        eo = exp_out.pop_front();
        chk("if_pc_instr", {if_pc, if_instr}, eo);
        chk("if_opcode", {58'h0, if_opcode}, {58'h0, eo[31:26]});
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_addr", {32'h0, imem_addr}, 64'h0);
    chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_if_instr", {32'h0, if_instr}, 64'h0);
    chk("rst_if_pc", {32'h0, if_pc}, 64'h0);
    chk("rst_opcode", {58'h0, if_opcode}, 64'h0);
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_out.push_back({32'h0, 32'h8C41_0004});
    rst = 0;
    wait_valid();
    chk("t2_opcode", {58'h0, if_opcode}, {58'h0, 6'b100011});
    chk("t2_instr", {32'h0, if_instr}, {32'h0, 32'h8C41_0004});
    chk("t2_pc", {32'h0, if_pc}, 64'h0);
    wait_req(32'h4);
    if_ready = 0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", {63'h0, if_valid}, 64'h1);
      chk("t3_hold_instr", {32'h0, if_instr}, {32'h0, 32'hA000_0004});
      chk("t3_hold_pc", {32'h0, if_pc}, 64'h4);
      chk("t3_no_req", {63'h0, imem_req_valid}, 64'h0);
      @(negedge clk);
    end
    mem_lat = 2;
    exp_out.push_back({32'h4, 32'hA000_0004});
    exp_addr.push_back(32'h8);
    if_ready = 1;
    wait_req(32'h8);
    @(negedge clk);
    redirect_valid = 1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    redirect_valid = 0;
    chk("t4_flush_valid", {63'h0, if_valid}, 64'h0);
    chk("t4_no_req_drop", {63'h0, imem_req_valid}, 64'h0);
    exp_addr.push_back(32'h40);
    exp_addr.push_back(32'h44);
    exp_out.push_back({32'h40, 32'hA000_0040});
    wait_req(32'h44);
    if_ready = 0;
    wait_valid();
    chk("t5_hold_pc", {32'h0, if_pc}, 64'h44);
    if_ready       = 1;
    redirect_valid = 1;
    redirect_pc    = 32'h80;
    @(negedge clk);
    redirect_valid = 0;
    chk("t5_flushed", {63'h0, if_valid}, 64'h0);
    chk("t5_next_addr", {32'h0, imem_addr}, 64'h80);
    exp_addr.push_back(32'h80);
    exp_addr.push_back(32'h84);
    exp_out.push_back({32'h80, 32'hA000_0080});
    wait_req(32'h84);
    if_ready = 0;
    wait_valid();
    redirect_valid = 1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 0;
    if_ready       = 1;
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    exp_out.push_back({32'hFFFF_FFFC, 32'hA0FF_FFFC});
    wait_req(32'h0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t6_rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("t6_rst_addr", {32'h0, imem_addr}, 64'h0);
    chk("t6_rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("t6_rst_if_instr", {32'h0, if_instr}, 64'h0);
    chk("t6_rst_if_pc", {32'h0, if_pc}, 64'h0);
    chk("t6_rst_opcode", {58'h0, if_opcode}, 64'h0);
    exp_addr.push_back(32'h0);
    exp_out.push_back({32'h0, 32'h8C41_0004});
    rst = 0;
    for (int i = 0; i < 200 && (exp_addr.size() != 0 || exp_out.size() != 0); i++) @(negedge clk);
    chk("drain_addr_q", {32'h0, 32'(exp_addr.size())}, 64'h0);
    chk("drain_out_q", {32'h0, 32'(exp_out.size())}, 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
